// File: rtl/instr_fetch_loader.sv
// Program store and byte-serial loader feeding a single-cycle RV32I core.
// Instructions are fetched combinationally; the core is gated by cpu_run until a load commits.
module instr_fetch_loader #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned PC_WIDTH   = 12,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [7:0]            load_byte,
  output logic                  load_ready,
  input  logic [PC_WIDTH-1:0]   count,
  output logic [31:0]           instr,
  output logic                  cpu_run,
  output logic                  load_done,
  output logic                  load_error,
  output logic [DEPTH_LOG2:0]   word_count
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = DEPTH_LOG2 + 1;
  localparam int unsigned PCW_W = PC_WIDTH - 2;
  localparam int unsigned CMP_W = (PCW_W > CNT_W) ? PCW_W : CNT_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR0  = 3'd1,
    HDR1  = 3'd2,
    DATA  = 3'd3,
    RUN   = 3'd4,
    ERROR = 3'd5
  } state_t;

  state_t            state;
  logic [7:0]        hdr_lo;
  logic [CNT_W-1:0]  word_target;
  logic [CNT_W-1:0]  word_ptr;
  logic [CNT_W-1:0]  word_ptr_nxt;
  logic [1:0]        byte_idx;
  logic [23:0]       word_buf;
  logic [15:0]       hdr_n;
  logic              hdr_bad;
  logic              xfer;
  logic              wr_en;
  logic [31:0]       store [DEPTH];

  assign xfer         = load_valid && load_ready;
  assign word_ptr_nxt = word_ptr + CNT_W'(1);
  assign hdr_n        = {load_byte, hdr_lo};
  assign hdr_bad      = (hdr_n == 16'd0) || (32'(hdr_n) > 32'(DEPTH));
  // load_start wins over a byte presented in the same cycle
  assign wr_en        = (state == DATA) && xfer && !load_start && (byte_idx == 2'd3);

  // Loader FSM with registered handshake and status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      load_ready  <= 1'b0;
      cpu_run     <= 1'b0;
      load_done   <= 1'b0;
      load_error  <= 1'b0;
      word_count  <= '0;
      word_ptr    <= '0;
      byte_idx    <= 2'd0;
      hdr_lo      <= 8'd0;
      word_target <= '0;
      word_buf    <= 24'd0;
    end else begin
      load_done <= 1'b0;
      if (load_start) begin
        state      <= HDR0;
        load_ready <= 1'b1;
        cpu_run    <= 1'b0;
        load_error <= 1'b0;
        word_count <= '0;
        word_ptr   <= '0;
        byte_idx   <= 2'd0;
      end else begin
        case (state)
          IDLE: ;
          HDR0: begin
            if (xfer) begin
              hdr_lo <= load_byte;
              state  <= HDR1;
            end
          end
          HDR1: begin
            if (xfer) begin
              if (hdr_bad) begin
                state      <= ERROR;
                load_ready <= 1'b0;
                load_error <= 1'b1;
              end else begin
                word_target <= CNT_W'(hdr_n);
                word_ptr    <= '0;
                byte_idx    <= 2'd0;
                state       <= DATA;
              end
            end
          end
          DATA: begin
            if (xfer) begin
              byte_idx <= byte_idx + 2'd1;
              case (byte_idx)
                2'd0:    word_buf[7:0]   <= load_byte;
                2'd1:    word_buf[15:8]  <= load_byte;
                2'd2:    word_buf[23:16] <= load_byte;
                default: begin
                  word_ptr <= word_ptr_nxt;
                  if (word_ptr_nxt == word_target) begin
                    word_count <= word_target;
                    load_done  <= 1'b1;
                    cpu_run    <= 1'b1;
                    load_ready <= 1'b0;
                    state      <= RUN;
                  end
                end
              endcase
            end
          end
          RUN:     ;
          ERROR:   ;
          default: begin
            state      <= IDLE;
            load_ready <= 1'b0;
          end
        endcase
      end
    end
  end

  // Program store; contents survive reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      store[word_ptr[DEPTH_LOG2-1:0]] <= {load_byte, word_buf};
    end
  end

  // Zero-latency fetch; anything outside the committed program reads as NOP
  logic [CMP_W-1:0] fetch_word;
  always_comb begin
    fetch_word = CMP_W'(count[PC_WIDTH-1:2]);
    instr      = NOP_WORD;
    if (cpu_run && (count[1:0] == 2'b00) && (fetch_word < CMP_W'(word_count))) begin
      instr = store[fetch_word[DEPTH_LOG2-1:0]];
    end
  end

endmodule

// File: tb/tb_instr_fetch_loader.sv
// Self-checking bench for instr_fetch_loader: scoreboarded loads, header errors,
// restarts and asynchronous reset.
module tb_instr_fetch_loader;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic        load_valid;
  logic [7:0]  load_byte;
  logic        load_ready;
  logic [11:0] count;
  logic [31:0] instr;
  logic        cpu_run;
  logic        load_done;
  logic        load_error;
  logic [10:0] word_count;

  int checks = 0;
  int errors = 0;
  int ready_seen = 0;
  int done_cnt = 0;
  logic [31:0] exp_q[$];

  instr_fetch_loader dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_byte  (load_byte),
    .load_ready (load_ready),
    .count      (count),
    .instr      (instr),
    .cpu_run    (cpu_run),
    .load_done  (load_done),
    .load_error (load_error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (load_done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One byte over the handshake, optionally with random valid gaps
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    bit acc = 1'b0;
    int tries = 0;
    while (!acc && tries < 200) begin
      load_byte  = b;
      load_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (load_ready) ready_seen++;
      acc = load_valid && load_ready;
      @(negedge clk);
      tries++;
    end
    load_valid = 1'b0;
    if (!acc) check("byte_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_hdr(input logic [15:0] n, input bit rnd);
    send_byte(n[7:0], rnd);
    send_byte(n[15:8], rnd);
  endtask

  task automatic send_word(input logic [31:0] w, input bit rnd);
    exp_q.push_back(w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], rnd);
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(negedge clk);
    load_start = 1'b0;
    exp_q.delete();
  endtask

  // Pop scoreboard words and compare against fetches at consecutive word addresses
  task automatic verify_prog(input string tag);
    int i = 0;
    while (exp_q.size() > 0) begin
      count = 12'(4 * i);
      #1;
      check(tag, instr, exp_q.pop_front());
      i++;
    end
    count = 12'd0;
  endtask

  task automatic fetch_nop(input string tag, input logic [11:0] addr);
    count = addr;
    #1;
    check(tag, instr, NOP);
  endtask

  initial begin
    reset = 1'b0; load_start = 1'b0; load_valid = 1'b0; load_byte = 8'd0; count = 12'd0;
    repeat (3) @(negedge clk);
    check("rst_cpu_run", 32'(cpu_run), 32'd0);
    check("rst_ready", 32'(load_ready), 32'd0);
    check("rst_wc", 32'(word_count), 32'd0);
    check("rst_err", 32'(load_error), 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_ready", 32'(load_ready), 32'd0);

    // Back-to-back stream
    pulse_start();
    ready_seen = 0; done_cnt = 0;
    send_hdr(16'd2, 1'b0);
    send_word(32'h0010_0513, 1'b0);
    send_word(32'h0020_0593, 1'b0);
    check("t1_done_pulse", 32'(load_done), 32'd1);
    check("t1_ready_cycles", 32'(ready_seen), 32'd10);
    check("t1_ready_low", 32'(load_ready), 32'd0);
    @(negedge clk);
    check("t1_done_clear", 32'(load_done), 32'd0);
    check("t1_done_cnt", 32'(done_cnt), 32'd1);
    check("t1_cpu_run", 32'(cpu_run), 32'd1);
    check("t1_wc", 32'(word_count), 32'd2);
    verify_prog("t1_fetch");
    fetch_nop("t1_nop_c8", 12'd8);
    fetch_nop("t1_nop_c2", 12'd2);

    // Same program, random valid gaps
    pulse_start();
    done_cnt = 0;
    send_hdr(16'd2, 1'b1);
    send_word(32'h0010_0513, 1'b1);
    send_word(32'h0020_0593, 1'b1);
    repeat (3) @(negedge clk);
    check("t2_done_cnt", 32'(done_cnt), 32'd1);
    check("t2_wc", 32'(word_count), 32'd2);
    verify_prog("t2_fetch");

    // Rejected headers: N=0 and N=1025
    for (int k = 0; k < 2; k++) begin
      pulse_start();
      send_hdr(k == 0 ? 16'h0000 : 16'h0401, 1'b0);
      check("t3_err", 32'(load_error), 32'd1);
      check("t3_ready", 32'(load_ready), 32'd0);
      check("t3_cpu_run", 32'(cpu_run), 32'd0);
      fetch_nop("t3_nop0", 12'd0);
      fetch_nop("t3_nop4", 12'd4);
      fetch_nop("t3_nopfff", 12'hFFC);
    end

    // Three-word program, then restart with a one-word program
    pulse_start();
    send_hdr(16'd3, 1'b0);
    send_word(32'h1111_1111, 1'b0);
    send_word(32'h2222_2222, 1'b0);
    send_word(32'h3333_3333, 1'b0);
    check("t4_run3", 32'(cpu_run), 32'd1);
    verify_prog("t4_fetch3");
    pulse_start();
    check("t4_run_off", 32'(cpu_run), 32'd0);
    check("t4_err_off", 32'(load_error), 32'd0);
    send_hdr(16'd1, 1'b0);
    check("t4_run_loading", 32'(cpu_run), 32'd0);
    send_word(32'hDEAD_BEEF, 1'b0);
    check("t4_run_on", 32'(cpu_run), 32'd1);
    check("t4_wc", 32'(word_count), 32'd1);
    verify_prog("t4_fetch1");
    fetch_nop("t4_stale4", 12'd4);
    fetch_nop("t4_stale8", 12'd8);

    // load_start collides with a valid byte in DATA; that byte must be dropped
    pulse_start();
    send_hdr(16'd2, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'h55, 1'b0);
    load_start = 1'b1; load_valid = 1'b1; load_byte = 8'hAA;
    @(negedge clk);
    load_start = 1'b0; load_valid = 1'b0;
    exp_q.delete();
    check("t5_ready_hdr0", 32'(load_ready), 32'd1);
    send_hdr(16'd1, 1'b0);
    send_word(32'h4433_2211, 1'b0);
    check("t5_done", 32'(load_done), 32'd1);
    check("t5_wc", 32'(word_count), 32'd1);
    verify_prog("t5_fetch");

    // Asynchronous reset in the middle of DATA
    pulse_start();
    send_hdr(16'd2, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'h77, 1'b0);
    #3 reset = 1'b0;
    #1;
    check("t6_ready_async", 32'(load_ready), 32'd0);
    check("t6_run_async", 32'(cpu_run), 32'd0);
    check("t6_wc_async", 32'(word_count), 32'd0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_idle_ready", 32'(load_ready), 32'd0);
    check("t6_idle_run", 32'(cpu_run), 32'd0);
    fetch_nop("t6_nop", 12'd0);
    pulse_start();
    check("t6_restart_ready", 32'(load_ready), 32'd1);
    send_hdr(16'd1, 1'b0);
    send_word(32'hCAFE_F00D, 1'b0);
    verify_prog("t6_fetch");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
